clk_sync_pulse: RTL and testbench



---
 rtl/clk_sync_pkg.sv | 24 ++
 rtl/clk_sync_pulse_sync_ff_chain.sv | 29 ++
 rtl/clk_sync_pulse.sv | 54 +++++
 tb/tb_clk_sync_pulse.sv | 117 +++++++++++
 4 files changed

// File: rtl/clk_sync_pkg.sv
// Shared constants for the pulse synchronizer: edge-select codes and synchronizer depth bounds.
// Latency: n/a (package).
// Backpressure: n/a (package).
package clk_sync_pkg;

    // Edge-select codes for clk_sync_pulse EDGE_MODE
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // Legal synchronizer depth range
    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

    // Edge term for one channel given the synchronized level and its one-cycle-old copy.
    function automatic logic edge_term(input int mode, input logic last, input logic prev);
        case (mode)
            EDGE_FALL: return ~last & prev;
            EDGE_BOTH: return last ^ prev;
            default:   return last & ~prev;
        endcase
    endfunction

endpackage

// File: rtl/clk_sync_pulse_sync_ff_chain.sv
// Single-bit multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: STAGES clk edges from the first sampling edge to q.
// Backpressure: none; free-running sampler.
// Ports: clk (sole clock), rst (sync active-high), d (async input), q (synchronized level).
module sync_ff_chain
    import clk_sync_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Pure flop chain: no logic between stages so each stage gets a full period to resolve.
    (* async_reg = "true" *) logic [STAGES-1:0] s;

    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
        end else begin
            s <= {s[STAGES-2:0], d};
        end
    end

    assign q = s[STAGES-1];

endmodule

// File: rtl/clk_sync_pulse.sv
// Synchronizes WIDTH asynchronous lines into clk and emits a one-cycle strobe per selected edge.
// Latency: strobe high after edge E+SYNC_STAGES, where E is the first edge sampling the new level.
// Backpressure: none; every detected edge yields exactly one strobe.
// Ports: clk (sole clock), rst (sync active-high), pulse[WIDTH] (async inputs),
//        pulse_sync[WIDTH] (registered one-cycle strobes, one per channel).
module clk_sync_pulse
    import clk_sync_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] pulse_sync
);

    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
        $error("clk_sync_pulse: SYNC_STAGES must be within 2..4");
    end

    if (EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH) begin : g_bad_mode
        $error("clk_sync_pulse: EDGE_MODE must be 0, 1 or 2");
    end

    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] prev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_ff_chain #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (pulse[i]),
            .q   (last[i])
        );
    end

    // prev and the strobe clear together with the chain so an edge in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            pulse_sync <= '0;
        end else begin
            prev <= last;
            for (int i = 0; i < WIDTH; i++) begin
                pulse_sync[i] <= edge_term(EDGE_MODE, last[i], prev[i]);
            end
        end
    end

endmodule

// File: tb/tb_clk_sync_pulse.sv
module tb_clk_sync_pulse;
    import clk_sync_pkg::*;

    logic       clk;
    logic       rst;
    logic       p;
    logic [3:0] pm;
    logic       ps_r;
    logic       ps_f;
    logic       ps_b;
    logic [3:0] ps_m;

    int n_checks = 0;
    int n_fails  = 0;

    clk_sync_pulse #(.WIDTH(1), .SYNC_STAGES(2), .EDGE_MODE(EDGE_RISE)) u_rise (
        .clk(clk), .rst(rst), .pulse(p), .pulse_sync(ps_r));
    clk_sync_pulse #(.WIDTH(1), .SYNC_STAGES(2), .EDGE_MODE(EDGE_FALL)) u_fall (
        .clk(clk), .rst(rst), .pulse(p), .pulse_sync(ps_f));
    clk_sync_pulse #(.WIDTH(1), .SYNC_STAGES(2), .EDGE_MODE(EDGE_BOTH)) u_both (
        .clk(clk), .rst(rst), .pulse(p), .pulse_sync(ps_b));
    clk_sync_pulse #(.WIDTH(4), .SYNC_STAGES(3), .EDGE_MODE(EDGE_RISE)) u_multi (
        .clk(clk), .rst(rst), .pulse(pm), .pulse_sync(ps_m));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_all(input logic er, input logic ef, input logic eb,
                             input logic [3:0] em, input string tag);
        n_checks++;
        assert (ps_r === er) else begin
            n_fails++;
            $error("FAIL %s rise: got %b expected %b", tag, ps_r, er);
        end
        n_checks++;
        assert (ps_f === ef) else begin
            n_fails++;
            $error("FAIL %s fall: got %b expected %b", tag, ps_f, ef);
        end
        n_checks++;
        assert (ps_b === eb) else begin
            n_fails++;
            $error("FAIL %s both: got %b expected %b", tag, ps_b, eb);
        end
        n_checks++;
        assert (ps_m === em) else begin
            n_fails++;
            $error("FAIL %s multi: got %b expected %b", tag, ps_m, em);
        end
    endtask

    // Called at posedge+1: inputs change at posedge+15 (T/4 after the falling edge),
    // the next posedge samples them, outputs are checked 1 time unit after that edge.
    task automatic step(input logic rv, input logic pv, input logic [3:0] mv,
                        input logic er, input logic ef, input logic eb,
                        input logic [3:0] em, input string tag);
        #14;
        rst = rv;
        p   = pv;
        pm  = mv;
        @(posedge clk);
        #1;
        check_all(er, ef, eb, em, tag);
    endtask

    initial begin
        logic pat;
        logic er;
        logic ef;
        rst = 1'b1;
        p   = 1'b0;
        pm  = 4'b0000;

        // Reset: three reset edges, then five idle edges, strobes stay low.
        @(posedge clk);
        #1;
        check_all(1'b0, 1'b0, 1'b0, 4'b0, "reset0");
        step(1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, "reset1");
        step(1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, "reset2");
        for (int j = 0; j < 5; j++)
            step(1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, $sformatf("post_reset%0d", j));

        // Rising edge held 52 cycles: one strobe two edges after the first sampling edge.
        for (int j = 0; j < 52; j++)
            step(1'b0, 1'b1, 4'b0, (j == 2), 1'b0, (j == 2), 4'b0, $sformatf("hold_hi%0d", j));

        // Falling edge: only fall and both modes fire.
        for (int j = 0; j < 6; j++)
            step(1'b0, 1'b0, 4'b0, 1'b0, (j == 2), (j == 2), 4'b0, $sformatf("fall%0d", j));

        // Back-to-back: 2 high / 2 low, four times.
        for (int j = 0; j < 20; j++) begin
            pat = (j < 16) && ((j % 4) < 2);
            er  = (j == 2) || (j == 6) || (j == 10) || (j == 14);
            ef  = (j == 4) || (j == 8) || (j == 12) || (j == 16);
            step(1'b0, pat, 4'b0, er, ef, er | ef, 4'b0, $sformatf("b2b%0d", j));
        end

        // Mid-flight reset: input sampled at step 0, reset on the next two edges.
        step(1'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, "mid0");
        step(1'b1, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, "mid1");
        step(1'b1, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, "mid2");
        for (int j = 3; j < 9; j++)
            step(1'b0, 1'b1, 4'b0, (j == 5), 1'b0, (j == 5), 4'b0, $sformatf("mid%0d", j));
        for (int j = 0; j < 6; j++)
            step(1'b0, 1'b0, 4'b0, 1'b0, (j == 2), (j == 2), 4'b0, $sformatf("mid_fall%0d", j));

        // Multi-channel, three stages: channels 0 and 2 rise together.
        for (int j = 0; j < 7; j++)
            step(1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, (j == 3) ? 4'b0101 : 4'b0000,
                 $sformatf("multi%0d", j));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
